error_lockout_ctrl: RTL
=======================

Name: error_lockout_ctrl

Overview:
- Parametrised successor to the wrong-password error processor in the lock datapath.
- Counts wrong-password events and asserts `gen_stop` to block the keypad/generator for a timed lockout.
- Lockout duration doubles with each successive lockout; after `MAX_LEVEL` lockouts it latches a permanent alarm until an admin unlock.
- Sits between password comparator and keypad/generator enable.

Parameters:
- MAX_ERR, 3, wrong attempts per round that trigger a lockout (>=1).
- CNT_W, 4, width of `error_counter`; must satisfy 2^CNT_W > MAX_ERR.
- LOCK_CYCLES, 1000, clock cycles of first lockout.
- MAX_LEVEL, 3, lockouts allowed before ALARM (>=1).
- LVL_W, 2, width of `lock_level`; must satisfy 2^LVL_W > MAX_LEVEL.
- TMR_W, 16, width of lockout timer; must hold LOCK_CYCLES<<(MAX_LEVEL-1).
- DECAY_CYCLES, 5000, idle cycles per counter decay (optional feature only).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_in  in  1  synchronous active-high reset.
- gen_rst  in  1  wrong-password indication; each rising edge = one error.
- ok_pulse  in  1  correct-password indication (level, sampled each cycle).
- rst_out  in  1  admin unlock; synchronous, clears everything except the `gen_rst` edge register.
- gen_stop  out  1  1 = input blocked (LOCKED or ALARM).
- alarm  out  1  1 = ALARM state.
- error_counter  out  CNT_W  errors in current round.
- lock_level  out  LVL_W  lockouts taken since last clear.
- lock_remaining  out  TMR_W  cycles left in current lockout, 0 otherwise.

Behaviour:
- Reset (rst_in=1 at a clk edge): state=IDLE; all outputs 0; `gen_rst` edge register cleared.
- Edge detect: err_evt = gen_rst & ~gen_rst_q, with gen_rst_q registered every cycle. A held `gen_rst` counts once. All outputs are registered and update on the same edge that first samples gen_rst=1.
- Priority per cycle: rst_in > rst_out > ok_pulse > err_evt.
- States: IDLE, LOCKED, ALARM.
- IDLE:
  - ok_pulse=1: error_counter<=0, lock_level<=0. Any err_evt in that cycle is dropped.
  - err_evt with error_counter<MAX_ERR-1: error_counter+1.
  - err_evt with error_counter==MAX_ERR-1 and lock_level<MAX_LEVEL: go to LOCKED; error_counter<=MAX_ERR; lock_level+1; lock_remaining<=LOCK_CYCLES<<lock_level, using the old level.
  - err_evt with error_counter==MAX_ERR-1 and lock_level==MAX_LEVEL: go to ALARM; error_counter<=MAX_ERR.
- LOCKED:
  - gen_stop=1.
  - err_evt and ok_pulse ignored; the edge register still tracks `gen_rst`.
  - lock_remaining decrements by 1 each cycle.
  - In the cycle lock_remaining==1: next state IDLE, lock_remaining<=0, error_counter<=0, lock_level retained.
  - gen_stop is therefore high for exactly the lockout duration in cycles.
- ALARM: gen_stop=1, alarm=1; only rst_in or rst_out exit.
- rst_out=1 in any state: go to IDLE; error_counter, lock_level, lock_remaining, alarm all 0.
- Counters never wrap: error_counter is capped at MAX_ERR, lock_level at MAX_LEVEL.
- A reset mid-lockout aborts the timer immediately; no residual gen_stop.

Optional Feature:
- Macro: ERR_DECAY_EN.
- Defined: in IDLE, a decay timer counts cycles with no err_evt. When it reaches DECAY_CYCLES and error_counter>0, error_counter decrements by 1 and the timer restarts.
  - The timer clears on err_evt, ok_pulse, rst_out, rst_in, and on entry to IDLE.
  - lock_level never decays.
- Undefined: no decay timer logic; error_counter holds until ok_pulse, lockout expiry or reset.

Test Plan:
- Config for all scenarios: MAX_ERR=3, LOCK_CYCLES=8, MAX_LEVEL=2, TMR_W=8, CNT_W=4, LVL_W=2.
- 1. Assert rst_in for 1 cycle -> all outputs 0, state IDLE.
- 2. Three 1-cycle `gen_rst` pulses 5 cycles apart:
  - error_counter goes 1, 2, then 3 with gen_stop=1, lock_level=1, lock_remaining=8.
  - gen_stop stays high exactly 8 cycles, then error_counter=0 and lock_level=1.
- 3. `gen_rst` pulses and ok_pulse during LOCKED -> no change to error_counter; lock_remaining keeps decrementing.
- 4. Second round of 3 errors:
  - Lockout of 16 cycles, lock_level=2.
  - Third round of 3 errors -> alarm=1 and gen_stop=1, held for 100 cycles.
  - rst_out pulse -> all outputs 0.
- 5. Two errors, then ok_pulse and a `gen_rst` edge in the same cycle -> error_counter=0. Holding `gen_rst` high for 10 cycles -> error_counter=1 only.
- 6. rst_in asserted with lock_remaining=5 -> next edge gen_stop=0, lock_remaining=0, lock_level=0. With ERR_DECAY_EN and DECAY_CYCLES=20: 2 errors followed by 40 idle cycles -> error_counter=0.

Source files
------------

// File: rtl/error_lockout_ctrl.sv
// Wrong-password lockout controller: escalating timed lockouts, then a latched alarm.
// Optional macro ERR_DECAY_EN: in IDLE, idle time slowly forgives counted errors.
module error_lockout_ctrl #(
  parameter int MAX_ERR      = 3,
  parameter int CNT_W        = 4,
  parameter int LOCK_CYCLES  = 1000,
  parameter int MAX_LEVEL    = 3,
  parameter int LVL_W        = 2,
  parameter int TMR_W        = 16,
  parameter int DECAY_CYCLES = 5000
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             gen_rst,
  input  logic             ok_pulse,
  input  logic             rst_out,
  output logic             gen_stop,
  output logic             alarm,
  output logic [CNT_W-1:0] error_counter,
  output logic [LVL_W-1:0] lock_level,
  output logic [TMR_W-1:0] lock_remaining
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCKED,
    ST_ALARM
  } state_t;

  localparam logic [CNT_W-1:0] ERR_LAST  = CNT_W'(MAX_ERR - 1);
  localparam logic [CNT_W-1:0] ERR_FULL  = CNT_W'(MAX_ERR);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(MAX_LEVEL);
  localparam logic [TMR_W-1:0] LOCK_BASE = TMR_W'(LOCK_CYCLES);

  // Reject configurations whose counters or timer could overflow.
  if (MAX_ERR < 1 || (longint'(1) << CNT_W) <= longint'(MAX_ERR)) begin : g_bad_cnt_w
    $error("error_lockout_ctrl: CNT_W too small or MAX_ERR < 1");
  end
  if (MAX_LEVEL < 1 || (longint'(1) << LVL_W) <= longint'(MAX_LEVEL)) begin : g_bad_lvl_w
    $error("error_lockout_ctrl: LVL_W too small or MAX_LEVEL < 1");
  end
  if ((longint'(LOCK_CYCLES) << (MAX_LEVEL - 1)) >= (longint'(1) << TMR_W)) begin : g_bad_tmr_w
    $error("error_lockout_ctrl: TMR_W cannot hold the longest lockout");
  end
  if (DECAY_CYCLES < 1) begin : g_bad_decay
    $error("error_lockout_ctrl: DECAY_CYCLES must be >= 1");
  end

  state_t           state_q, state_d;
  logic             gen_rst_q;
  logic             err_evt;
  logic [CNT_W-1:0] ec_d;
  logic [LVL_W-1:0] lvl_d;
  logic [TMR_W-1:0] rem_d;

`ifdef ERR_DECAY_EN
  localparam int               DEC_W      = $clog2(DECAY_CYCLES + 1);
  localparam logic [DEC_W-1:0] DECAY_LAST = DEC_W'(DECAY_CYCLES - 1);
  logic [DEC_W-1:0] decay_q, decay_d;
`endif

  // A held gen_rst counts once; only the rising edge is an error.
  assign err_evt = gen_rst & ~gen_rst_q;

  // NOTE: every variable gets a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    ec_d    = error_counter;
    lvl_d   = lock_level;
    rem_d   = lock_remaining;

    if (rst_out) begin
      state_d = ST_IDLE;
      ec_d    = '0;
      lvl_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ok_pulse) begin
            ec_d  = '0;
            lvl_d = '0;
          end else if (err_evt) begin
            if (error_counter < ERR_LAST) begin
              ec_d = error_counter + CNT_W'(1);
            end else if (lock_level < LVL_FULL) begin
              // Duration doubles per level, scaled by the level before increment.
              state_d = ST_LOCKED;
              ec_d    = ERR_FULL;
              lvl_d   = lock_level + LVL_W'(1);
              rem_d   = LOCK_BASE << lock_level;
            end else begin
              state_d = ST_ALARM;
              ec_d    = ERR_FULL;
            end
          end
        end
        ST_LOCKED: begin
          if (lock_remaining <= TMR_W'(1)) begin
            state_d = ST_IDLE;
            rem_d   = '0;
            ec_d    = '0;
          end else begin
            rem_d = lock_remaining - TMR_W'(1);
          end
        end
        ST_ALARM: ;
        default: state_d = ST_IDLE;
      endcase
    end

`ifdef ERR_DECAY_EN
    // Timer runs only on quiet IDLE cycles, so it is zero on every entry to IDLE.
    decay_d = '0;
    if (!rst_out && state_q == ST_IDLE && !ok_pulse && !err_evt) begin
      if (decay_q == DECAY_LAST) begin
        if (error_counter != '0) ec_d = error_counter - CNT_W'(1);
      end else begin
        decay_d = decay_q + DEC_W'(1);
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q        <= ST_IDLE;
      gen_rst_q      <= 1'b0;
      error_counter  <= '0;
      lock_level     <= '0;
      lock_remaining <= '0;
      gen_stop       <= 1'b0;
      alarm          <= 1'b0;
`ifdef ERR_DECAY_EN
      decay_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      gen_rst_q      <= gen_rst;
      error_counter  <= ec_d;
      lock_level     <= lvl_d;
      lock_remaining <= rem_d;
      gen_stop       <= (state_d != ST_IDLE);
      alarm          <= (state_d == ST_ALARM);
`ifdef ERR_DECAY_EN
      decay_q        <= decay_d;
`endif
    end
  end

endmodule
